// File: rtl/pwl_filter_reset_seq_if.sv
// Reset-side bundle between startup control, the reset sequencer and the PWL filter.
// Levels are signed fixed point with FracW fractional bits; fp_rst is in whole Hz.
interface pwl_filter_reset_seq_if #(
    parameter int unsigned DataW = 24,
    parameter int unsigned TimeW = 32,
    parameter int unsigned FpW   = 32,
    parameter int unsigned CntW  = 16
);
    logic                    req;
    logic signed [DataW-1:0] target;
    logic signed [DataW-1:0] out_fb;
    logic                    reset;
    logic signed [DataW-1:0] in_rst_val;
    logic signed [DataW-1:0] in_rst_slope;
    logic [TimeW-1:0]        in_rst_t0;
    logic [FpW-1:0]          fp_rst;
    logic                    busy;
    logic                    ack;
    logic                    timeout;
    logic [CntW-1:0]         cyc_used;

    modport master (
        output req, target, out_fb,
        input  reset, in_rst_val, in_rst_slope, in_rst_t0, fp_rst, busy, ack, timeout, cyc_used
    );

    modport slave (
        input  req, target, out_fb,
        output reset, in_rst_val, in_rst_slope, in_rst_t0, fp_rst, busy, ack, timeout, cyc_used
    );
endinterface

// File: rtl/pwl_filter_reset_seq.sv
// Reset initiator for a PWL linear filter: holds reset with a constant in_rst level until
// the edge-sampled filter output settles on the target, then releases and acknowledges.
module pwl_filter_reset_seq #(
    parameter int unsigned DataW        = 24,
    parameter int unsigned FracW        = 16,
    parameter int unsigned TimeW        = 32,
    parameter int unsigned FpW          = 32,
    parameter int unsigned CntW         = 16,
    parameter int          InvGain      = 65536,          // 1/gain in Q(FracW)
    parameter int unsigned ConvTol      = 655,            // settle band in Q(FracW)
    parameter int unsigned FpFast       = 1_000_000_000,  // reset-path pole, Hz
    parameter int unsigned MinHold      = 2,
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned Timeout      = 256             // must fit in CntW bits
) (
    input logic                   clk,
    input logic                   rstn,
    pwl_filter_reset_seq_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StAssert, StSettle, StRelease, StDone} state_e;

    localparam logic signed [2*DataW-1:0] GainExt = (2*DataW)'(InvGain);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [CntW-1:0]         inb_q, inb_d, inb_inc;
    logic signed [DataW-1:0] tgt_q, tgt_d;
    logic signed [DataW-1:0] in_rst_q, in_rst_d;
    logic [TimeW-1:0]        t0_q, t0_d;
    logic [TimeW-1:0]        now_q;
    logic                    reset_q, reset_d;
    logic [FpW-1:0]          fp_q, fp_d;
    logic                    busy_q, busy_d;
    logic                    ack_q, ack_d;
    logic                    timeout_q, timeout_d;
    logic [CntW-1:0]         cyc_used_q, cyc_used_d;

    logic signed [2*DataW-1:0] tgt_ext;
    logic signed [2*DataW-1:0] prod;
    logic signed [DataW:0]     diff;
    logic [DataW:0]            abs_diff;
    logic                      in_band;

    assign tgt_ext  = {{DataW{bus.target[DataW-1]}}, bus.target};
    assign prod     = tgt_ext * GainExt;
    assign diff     = {bus.out_fb[DataW-1], bus.out_fb} - {tgt_q[DataW-1], tgt_q};
    assign abs_diff = diff[DataW] ? unsigned'(-diff) : unsigned'(diff);
    assign in_band  = abs_diff <= (DataW+1)'(ConvTol);

    // Both counters saturate rather than wrap.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign inb_inc = (inb_q == '1) ? inb_q : inb_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inb_d      = inb_q;
        tgt_d      = tgt_q;
        in_rst_d   = in_rst_q;
        t0_d       = t0_q;
        reset_d    = reset_q;
        fp_d       = fp_q;
        busy_d     = busy_q;
        ack_d      = ack_q;
        timeout_d  = timeout_q;
        cyc_used_d = cyc_used_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    tgt_d     = bus.target;
                    in_rst_d  = DataW'(prod >>> FracW);
                    t0_d      = now_q;
                    reset_d   = 1'b1;
                    fp_d      = FpW'(FpFast);
                    busy_d    = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = CntW'(1);
                    inb_d     = '0;
                    state_d   = StAssert;
                end
            end
            StAssert, StSettle: begin
                if (!bus.req) begin
                    // Abort: drop reset without acknowledging.
                    reset_d    = 1'b0;
                    fp_d       = '0;
                    busy_d     = 1'b0;
                    timeout_d  = 1'b0;
                    cyc_used_d = cnt_q;
                    state_d    = StIdle;
                end else if (state_q == StAssert) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CntW'(MinHold)) begin
                        inb_d   = '0;
                        state_d = StSettle;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    inb_d = in_band ? inb_inc : '0;
                    // Success is tested first so it wins over a coincident timeout.
                    if (in_band && inb_inc >= CntW'(SettleCycles)) begin
                        state_d = StRelease;
                    end else if (cnt_inc >= CntW'(Timeout)) begin
                        timeout_d = 1'b1;
                        state_d   = StRelease;
                    end
                end
            end
            StRelease: begin
                reset_d    = 1'b0;
                fp_d       = '0;
                cyc_used_d = cnt_q;
                state_d    = StDone;
            end
            StDone: begin
                busy_d = 1'b0;
                if (!bus.req) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            inb_q      <= '0;
            tgt_q      <= '0;
            in_rst_q   <= '0;
            t0_q       <= '0;
            now_q      <= '0;
            reset_q    <= 1'b0;
            fp_q       <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
            cyc_used_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inb_q      <= inb_d;
            tgt_q      <= tgt_d;
            in_rst_q   <= in_rst_d;
            t0_q       <= t0_d;
            now_q      <= now_q + 1'b1;
            reset_q    <= reset_d;
            fp_q       <= fp_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            timeout_q  <= timeout_d;
            cyc_used_q <= cyc_used_d;
        end
    end

    // in_rst is a constant segment: only the level and its start time ever change.
    assign bus.reset        = reset_q;
    assign bus.in_rst_val   = in_rst_q;
    assign bus.in_rst_slope = '0;
    assign bus.in_rst_t0    = t0_q;
    assign bus.fp_rst       = fp_q;
    assign bus.busy         = busy_q;
    assign bus.ack          = ack_q;
    assign bus.timeout      = timeout_q;
    assign bus.cyc_used     = cyc_used_q;

endmodule
